lenet5_weight_sched: RTL

Sequencer that owns the single shared weight/bias ROM read port for the LeNet-5 accelerator. It streams all parameter segments into their on-chip weight buffers in a fixed order, under a start/busy/done handshake: conv1 weights, conv2 weights for input channels 1 to 4, FC weights, then FC biases. It then holds a `loaded` flag that gates feature-map streaming into conv layer 1. It replaces the per-buffer free-running load counters at the top level.

---
 rtl/lenet5_weight_sched_pkg.sv | 77 +++++++
 rtl/lenet5_weight_sched_if.sv | 30 +++
 rtl/lenet5_weight_sched_seg_addr_gen.sv | 69 ++++++
 rtl/lenet5_weight_sched.sv | 139 +++++++++++++
 4 files changed

// File: rtl/lenet5_weight_sched_pkg.sv
// Shared constants for the LeNet-5 parameter loader: network sizes, the
// layout of parameter segments in the weight ROM, and small helper functions.
package lenet5_weight_sched_pkg;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

  localparam int W_BW    = 8;
  localparam int D_BW    = 16;
  localparam int K_SIZE  = 5;
  localparam int CO1     = 3;
  localparam int CO2     = 3;
  localparam int CI2     = 4;
  localparam int CI3     = 3;
  localparam int I_SIZE3 = 4;
  localparam int CO3     = 10;

  localparam int N1    = CO1 * K_SIZE * K_SIZE;
  localparam int N2    = CO2 * K_SIZE * K_SIZE;
  localparam int NFC   = CI3 * CO3 * I_SIZE3 * I_SIZE3;
  localparam int NB    = CO3;
  localparam int TOTAL = N1 + CI2 * N2 + NFC + NB;
  localparam int A_BW  = clog2(TOTAL);

  typedef logic [A_BW-1:0] addr_t;
  typedef logic [D_BW-1:0] word_t;
  typedef logic [2:0]      seg_id_t;

  localparam seg_id_t SEG_C1   = 3'd0;
  localparam seg_id_t SEG_C2_1 = 3'd1;
  localparam seg_id_t SEG_C2_2 = 3'd2;
  localparam seg_id_t SEG_C2_3 = 3'd3;
  localparam seg_id_t SEG_C2_4 = 3'd4;
  localparam seg_id_t SEG_FCW  = 3'd5;
  localparam seg_id_t SEG_FCB  = 3'd6;

  function automatic addr_t seg_len(input seg_id_t id);
    addr_t len;
    case (id)
      SEG_C1:                                 len = addr_t'(N1);
      SEG_C2_1, SEG_C2_2, SEG_C2_3, SEG_C2_4: len = addr_t'(N2);
      SEG_FCW:                                len = addr_t'(NFC);
      SEG_FCB:                                len = addr_t'(NB);
      default:                                len = '0;
    endcase
    return len;
  endfunction

  function automatic addr_t seg_base(input seg_id_t id);
    addr_t base;
    base = '0;
    for (int k = 0; k < 7; k++) begin
      if (seg_id_t'(k) < id) base = base + seg_len(seg_id_t'(k));
      else                   base = base;
    end
    return base;
  endfunction

  // Weights occupy only the low W_BW bits; re-extend so a sloppy ROM image
  // cannot leak junk into the upper bits. Biases use the full word.
  function automatic word_t fmt_word(input word_t raw, input seg_id_t id);
    word_t w;
    if (id == SEG_FCB) w = raw;
    else               w = {{(D_BW-W_BW){raw[W_BW-1]}}, raw[W_BW-1:0]};
    return w;
  endfunction

endpackage

// File: rtl/lenet5_weight_sched_if.sv
// Control, ROM-port and parameter-stream signals of the weight scheduler.
interface lenet5_weight_sched_if;
  import lenet5_weight_sched_pkg::*;

  logic    i_start;
  logic    i_hold;
  logic    i_rst_processEnd;
  logic    o_rom_rd;
  addr_t   o_rom_addr;
  word_t   i_rom_data;
  word_t   o_data;
  logic    o_valid;
  seg_id_t o_sel;
  logic    o_seg_last;
  logic    o_busy;
  logic    o_done;
  logic    o_loaded;

  modport slave (
    input  i_start, i_hold, i_rst_processEnd, i_rom_data,
    output o_rom_rd, o_rom_addr, o_data, o_valid, o_sel, o_seg_last,
           o_busy, o_done, o_loaded
  );

  modport master (
    output i_start, i_hold, i_rst_processEnd, i_rom_data,
    input  o_rom_rd, o_rom_addr, o_data, o_valid, o_sel, o_seg_last,
           o_busy, o_done, o_loaded
  );
endinterface

// File: rtl/lenet5_weight_sched_seg_addr_gen.sv
// ROM address walker: flat address plus segment id and offset within segment,
// advancing once per issued read and wrapping after the final word.
module lenet5_weight_sched_seg_addr_gen
  import lenet5_weight_sched_pkg::*;
(
  input  logic    clk,
  input  logic    global_rst_n,
  input  logic    i_clr,
  input  logic    i_adv,
  output addr_t   o_addr,
  output seg_id_t o_seg,
  output logic    o_seg_last,
  output logic    o_addr_last
);

  addr_t   addr_q, addr_d;
  addr_t   idx_q, idx_d;
  seg_id_t seg_q, seg_d;
  logic    seg_last_s;
  logic    addr_last_s;

  assign seg_last_s  = (idx_q == (seg_len(seg_q) - addr_t'(1)));
  assign addr_last_s = (addr_q == addr_t'(TOTAL - 1));

  always_comb begin
    addr_d = addr_q;
    idx_d  = idx_q;
    seg_d  = seg_q;
    if (i_clr) begin
      addr_d = '0;
      idx_d  = '0;
      seg_d  = SEG_C1;
    end else if (i_adv) begin
      if (addr_last_s) begin
        addr_d = '0;
        idx_d  = '0;
        seg_d  = SEG_C1;
      end else if (seg_last_s) begin
        addr_d = addr_q + addr_t'(1);
        idx_d  = '0;
        seg_d  = seg_q + 3'd1;
      end else begin
        addr_d = addr_q + addr_t'(1);
        idx_d  = idx_q + addr_t'(1);
        seg_d  = seg_q;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      addr_q <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_C1;
    end else begin
      addr_q <= addr_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
    end
  end

  assign o_addr      = addr_q;
  assign o_seg       = seg_q;
  assign o_seg_last  = seg_last_s;
  assign o_addr_last = addr_last_s;

endmodule

// File: rtl/lenet5_weight_sched.sv
// Owns the shared weight/bias ROM port: streams every parameter segment to its
// buffer on request, then holds o_loaded to release conv1 feature-map streaming.
module lenet5_weight_sched
  import lenet5_weight_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 global_rst_n,
  lenet5_weight_sched_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic       abort_s, start_s, rd_s, clr_s;
  addr_t      addr_s;
  seg_id_t    seg_s;
  logic       seg_last_s, addr_last_s;

  // ROM-stage copy of each read's sideband, then the output register.
  logic    rd1_q, rd1_d;
  seg_id_t sel1_q, sel1_d;
  logic    last1_q, last1_d;
  logic    valid_q, valid_d;
  word_t   data_q, data_d;
  seg_id_t sel_q, sel_d;
  logic    seg_last_q, seg_last_d;
  logic    busy_q, busy_d;
  logic    done_q, done_d;
  logic    loaded_q, loaded_d;

  assign abort_s = bus.i_rst_processEnd;
  assign start_s = (state_q == ST_IDLE) && bus.i_start && !abort_s;
  assign rd_s    = (state_q == ST_LOAD) && !bus.i_hold;
  assign clr_s   = start_s || abort_s;

  lenet5_weight_sched_seg_addr_gen u_addr_gen (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .i_clr        (clr_s),
    .i_adv        (rd_s),
    .o_addr       (addr_s),
    .o_seg        (seg_s),
    .o_seg_last   (seg_last_s),
    .o_addr_last  (addr_last_s)
  );

  always_comb begin
    state_d = state_q;
    if (abort_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.i_start) state_d = ST_LOAD; else state_d = ST_IDLE;
        ST_LOAD:  if (rd_s && addr_last_s) state_d = ST_DRAIN; else state_d = ST_LOAD;
        ST_DRAIN: if (rd1_q && last1_q) state_d = ST_DONE; else state_d = ST_DRAIN;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd1_d      = 1'b0;
    sel1_d     = sel1_q;
    last1_d    = 1'b0;
    valid_d    = 1'b0;
    data_d     = data_q;
    sel_d      = sel_q;
    seg_last_d = 1'b0;
    if (abort_s) begin
      sel1_d = SEG_C1;
      data_d = '0;
      sel_d  = SEG_C1;
    end else begin
      rd1_d   = rd_s;
      sel1_d  = seg_s;
      last1_d = rd_s && seg_last_s;
      valid_d = rd1_q;
      if (rd1_q) begin
        data_d     = fmt_word(bus.i_rom_data, sel1_q);
        sel_d      = sel1_q;
        seg_last_d = last1_q;
      end else begin
        data_d = data_q;
      end
    end
  end

  always_comb begin
    busy_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    done_d = (state_q == ST_DONE) && !abort_s;
    if (abort_s)                  loaded_d = 1'b0;
    else if (state_q == ST_DONE)  loaded_d = 1'b1;
    else if (start_s)             loaded_d = 1'b0;
    else                          loaded_d = loaded_q;
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q    <= ST_IDLE;
      rd1_q      <= 1'b0;
      sel1_q     <= SEG_C1;
      last1_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sel_q      <= SEG_C1;
      seg_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd1_q      <= rd1_d;
      sel1_q     <= sel1_d;
      last1_q    <= last1_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      seg_last_q <= seg_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      loaded_q   <= loaded_d;
    end
  end

  assign bus.o_rom_rd   = rd_s;
  assign bus.o_rom_addr = addr_s;
  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_sel      = sel_q;
  assign bus.o_seg_last = seg_last_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_loaded   = loaded_q;

endmodule
